// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like slave port between inst and data masters, with in-order response routing.
// Optional SRAM_ARB_RR_EN: round-robin on unlocked ties instead of fixed data-over-inst priority.
module sram_like_arbiter #(
  parameter int OST_DEPTH = 4,
  parameter int PTR_W     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [3:0]       inst_wstrb,
  input  logic [31:0]      inst_addr,
  input  logic [31:0]      inst_wdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [3:0]       data_wstrb,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  output logic             bus_req,
  output logic             bus_wr,
  output logic [1:0]       bus_size,
  output logic [3:0]       bus_wstrb,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  input  logic             bus_addr_ok,
  input  logic             bus_data_ok,
  input  logic [31:0]      bus_rdata,
  output logic [PTR_W:0]   ost_cnt,
  output logic             proto_err
);

  typedef enum logic {M_INST = 1'b0, M_DATA = 1'b1} master_e;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(OST_DEPTH);

  logic             lock_q, lock_d;
  master_e          lock_id_q, lock_id_d;
  master_e          fifo_q [OST_DEPTH];
  master_e          fifo_d [OST_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             proto_err_q, proto_err_d;
`ifdef SRAM_ARB_RR_EN
  master_e          rr_last_q, rr_last_d;
`endif

  logic    full, accept, pop;
  master_e sel, head;

  always_comb begin
    full = (cnt_q == CNT_FULL);
    if (lock_q) begin
      sel = lock_id_q;
    end else if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
      sel = (rr_last_q == M_INST) ? M_DATA : M_INST;
`else
      sel = M_DATA;
`endif
    end else if (data_req) begin
      sel = M_DATA;
    end else begin
      sel = M_INST;
    end
  end

  always_comb begin
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_size  = '0;
    bus_wstrb = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    if (!full) begin
      if (sel == M_DATA) begin
        bus_req = data_req;
      end else begin
        bus_req = inst_req;
      end
    end
    if (bus_req) begin
      if (sel == M_DATA) begin
        bus_wr    = data_wr;
        bus_size  = data_size;
        bus_wstrb = data_wstrb;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
      end else begin
        bus_wr    = inst_wr;
        bus_size  = inst_size;
        bus_wstrb = inst_wstrb;
        bus_addr  = inst_addr;
        bus_wdata = inst_wdata;
      end
    end
  end

  always_comb begin
    accept       = bus_req && bus_addr_ok;
    pop          = bus_data_ok && (cnt_q != '0);
    head         = fifo_q[rd_ptr_q];
    inst_addr_ok = accept && (sel == M_INST);
    data_addr_ok = accept && (sel == M_DATA);
    inst_data_ok = pop && (head == M_INST);
    data_data_ok = pop && (head == M_DATA);
    inst_rdata   = bus_rdata;
    data_rdata   = bus_rdata;
    ost_cnt      = cnt_q;
    proto_err    = proto_err_q;
  end

  always_comb begin
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    proto_err_d = proto_err_q | (bus_data_ok && (cnt_q == '0));
`ifdef SRAM_ARB_RR_EN
    rr_last_d   = rr_last_q;
`endif
    if (accept) begin
      lock_d           = 1'b0;
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = wr_ptr_q + 1'b1;
`ifdef SRAM_ARB_RR_EN
      rr_last_d        = sel;
`endif
    end else if (bus_req) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Count uses the registered value only: a pop while full frees the slot next cycle.
    if (accept && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!accept && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q      <= 1'b0;
      lock_id_q   <= M_INST;
      for (int unsigned i = 0; i < OST_DEPTH; i++) begin
        fifo_q[i] <= M_INST;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      rr_last_q   <= M_INST;
`endif
    end else begin
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      fifo_q      <= fifo_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
`ifdef SRAM_ARB_RR_EN
      rr_last_q   <= rr_last_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_sram_like_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, bus_size;
  logic [3:0]  inst_wstrb, data_wstrb, bus_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [2:0]  ost_cnt;
  logic        proto_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.OST_DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .ost_cnt(ost_cnt), .proto_err(proto_err)
  );

  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    inst_req = 0; data_req = 0; bus_addr_ok = 1; bus_data_ok = 1;
    @(negedge clk); #1;
    n_vec++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
    n_vec++; if (ost_cnt !== 3'd0) begin n_err++; $display("FAIL reset_ost_cnt: got %0d want 0", ost_cnt); end
    n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    n_vec++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin
      n_err++; $display("FAIL reset_oks: got %b want 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    reset = 0;
    idle();
  endtask

  task automatic test_single_read();
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2; bus_addr_ok = 1;
    #1;
    n_vec++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin n_err++; $display("FAIL single_addr_ok: got %b%b want 10", inst_addr_ok, data_addr_ok); end
    n_vec++; if (bus_addr !== 32'hBFC0_0000 || bus_size !== 2'd2 || bus_wr !== 1'b0) begin n_err++; $display("FAIL single_bus_addr: got %h want bfc00000", bus_addr); end
    @(negedge clk);
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3C1D_0001;
    #1;
    n_vec++; if (ost_cnt !== 3'd1) begin n_err++; $display("FAIL single_ost1: got %0d want 1", ost_cnt); end
    n_vec++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin n_err++; $display("FAIL single_data_ok: got %b%b want 10", inst_data_ok, data_data_ok); end
    n_vec++; if (inst_rdata !== 32'h3C1D_0001) begin n_err++; $display("FAIL single_rdata: got %h want 3c1d0001", inst_rdata); end
    @(negedge clk);
    bus_data_ok = 0;
    #1;
    n_vec++; if (ost_cnt !== 3'd0) begin n_err++; $display("FAIL single_ost0: got %0d want 0", ost_cnt); end
  endtask

  task automatic test_both_req();
    do_reset();
    inst_req = 1; inst_addr = 32'h100; data_req = 1; data_addr = 32'h200; bus_addr_ok = 1;
    #1;
    n_vec++; if ({inst_addr_ok, data_addr_ok} !== 2'b01 || bus_addr !== 32'h200) begin n_err++; $display("FAIL both_t0: got ok=%b addr=%h want 01/200", {inst_addr_ok, data_addr_ok}, bus_addr); end
    @(negedge clk);
    data_req = 0;
    #1;
    n_vec++; if ({inst_addr_ok, data_addr_ok} !== 2'b10 || bus_addr !== 32'h100) begin n_err++; $display("FAIL both_t1: got ok=%b addr=%h want 10/100", {inst_addr_ok, data_addr_ok}, bus_addr); end
    @(negedge clk);
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    #1;
    n_vec++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_err++; $display("FAIL both_t2: got %b want 01", {inst_data_ok, data_data_ok}); end
    @(negedge clk); #1;
    n_vec++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_err++; $display("FAIL both_t3: got %b want 10", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    bus_data_ok = 0;
    #1;
    n_vec++; if (ost_cnt !== 3'd0) begin n_err++; $display("FAIL both_ost: got %0d want 0", ost_cnt); end
  endtask

  task automatic test_full();
    do_reset();
    data_req = 1; bus_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      data_addr = 32'h1000 + 32'(k * 4);
      #1;
      n_vec++; if (data_addr_ok !== 1'b1) begin n_err++; $display("FAIL full_fill%0d: got %b want 1", k, data_addr_ok); end
      @(negedge clk);
    end
    data_addr = 32'h1010;
    #1;
    n_vec++; if (bus_req !== 1'b0 || data_addr_ok !== 1'b0 || ost_cnt !== 3'd4) begin n_err++; $display("FAIL full_block: got req=%b ok=%b cnt=%0d want 0/0/4", bus_req, data_addr_ok, ost_cnt); end
    @(negedge clk);
    bus_data_ok = 1;
    #1;
    n_vec++; if (data_data_ok !== 1'b1 || bus_req !== 1'b0) begin n_err++; $display("FAIL full_pop: got dok=%b req=%b want 1/0", data_data_ok, bus_req); end
    @(negedge clk);
    bus_data_ok = 0;
    #1;
    n_vec++; if (ost_cnt !== 3'd3 || data_addr_ok !== 1'b1 || bus_addr !== 32'h1010) begin n_err++; $display("FAIL full_refill: got cnt=%0d ok=%b addr=%h want 3/1/1010", ost_cnt, data_addr_ok, bus_addr); end
    @(negedge clk);
    data_req = 0;
    #1;
    n_vec++; if (ost_cnt !== 3'd4) begin n_err++; $display("FAIL full_cnt4: got %0d want 4", ost_cnt); end
  endtask

  task automatic test_lock();
    do_reset();
    data_req = 1; data_addr = 32'hA000;
    for (int k = 0; k < 3; k++) begin
      if (k >= 1) begin inst_req = 1; inst_addr = 32'hB000; end
      #1;
      n_vec++; if (bus_req !== 1'b1 || bus_addr !== 32'hA000 || {inst_addr_ok, data_addr_ok} !== 2'b00) begin
        n_err++; $display("FAIL lock_data_hold%0d: got req=%b addr=%h ok=%b want 1/a000/00", k, bus_req, bus_addr, {inst_addr_ok, data_addr_ok}); end
      @(negedge clk);
    end
    bus_addr_ok = 1;
    #1;
    n_vec++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin n_err++; $display("FAIL lock_data_acc: got %b want 01", {inst_addr_ok, data_addr_ok}); end
    @(negedge clk);
    data_req = 0;
    #1;
    n_vec++; if ({inst_addr_ok, data_addr_ok} !== 2'b10 || bus_addr !== 32'hB000) begin n_err++; $display("FAIL lock_inst_next: got ok=%b addr=%h want 10/b000", {inst_addr_ok, data_addr_ok}, bus_addr); end
    // Lower-priority inst locked first must keep the bus against a later data request.
    do_reset();
    inst_req = 1; inst_addr = 32'hC000;
    @(negedge clk);
    data_req = 1; data_addr = 32'hD000;
    #1;
    n_vec++; if (bus_addr !== 32'hC000 || data_addr_ok !== 1'b0) begin n_err++; $display("FAIL lock_inst_hold: got addr=%h dok=%b want c000/0", bus_addr, data_addr_ok); end
    @(negedge clk);
    bus_addr_ok = 1;
    #1;
    n_vec++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_err++; $display("FAIL lock_inst_acc: got %b want 10", {inst_addr_ok, data_addr_ok}); end
    @(negedge clk);
    inst_req = 0;
    #1;
    n_vec++; if ({inst_addr_ok, data_addr_ok} !== 2'b01 || bus_addr !== 32'hD000) begin n_err++; $display("FAIL lock_data_next: got ok=%b addr=%h want 01/d000", {inst_addr_ok, data_addr_ok}, bus_addr); end
  endtask

  task automatic test_proto_err();
    do_reset();
    bus_data_ok = 1;
    #1;
    n_vec++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_err++; $display("FAIL proto_no_dok: got %b want 00", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    bus_data_ok = 0;
    #1;
    n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_set: got %b want 1", proto_err); end
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (proto_err !== 1'b1 || ost_cnt !== 3'd0) begin n_err++; $display("FAIL proto_sticky: got err=%b cnt=%0d want 1/0", proto_err, ost_cnt); end
    data_req = 1; data_addr = 32'hE000; bus_addr_ok = 1;
    @(negedge clk);
    data_addr = 32'hE004; bus_addr_ok = 0;
    @(negedge clk);
    #1;
    n_vec++; if (ost_cnt !== 3'd1 || bus_req !== 1'b1) begin n_err++; $display("FAIL proto_prelock: got cnt=%0d req=%b want 1/1", ost_cnt, bus_req); end
    reset = 1; data_req = 0;
    #1;
    n_vec++; if (bus_req !== 1'b0 || ost_cnt !== 3'd0 || proto_err !== 1'b0) begin n_err++; $display("FAIL proto_midreset: got req=%b cnt=%0d err=%b want 0/0/0", bus_req, ost_cnt, proto_err); end
    @(negedge clk);
    reset = 0; inst_req = 1; inst_addr = 32'hF000;
    #1;
    n_vec++; if (bus_req !== 1'b1 || bus_addr !== 32'hF000) begin n_err++; $display("FAIL proto_unlock: got req=%b addr=%h want 1/f000", bus_req, bus_addr); end
    @(negedge clk);
    inst_req = 0; bus_data_ok = 1;
    @(negedge clk);
    bus_data_ok = 0;
    #1;
    n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_stale: got %b want 1", proto_err); end
  endtask

  task automatic test_priority();
    bit exp_data;
    do_reset();
    bus_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      inst_req = 1; inst_addr = 32'h300 + 32'(k);
      data_req = 1; data_addr = 32'h400 + 32'(k);
`ifdef SRAM_ARB_RR_EN
      exp_data = (k % 2 == 0);
`else
      exp_data = 1'b1;
`endif
      #1;
      n_vec++; if ({inst_addr_ok, data_addr_ok} !== {~exp_data, exp_data}) begin n_err++; $display("FAIL prio_grant%0d: got %b want %b", k, {inst_addr_ok, data_addr_ok}, {~exp_data, exp_data}); end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_random();
    logic        rq [2];
    logic        rwr [2];
    logic [1:0]  rsz [2];
    logic [3:0]  rsb [2];
    logic [31:0] rad [2];
    logic [31:0] rwd [2];
    int          q [$];
    int          held, rr_last, s;
    bit          perr, breq;
    logic [70:0] exp_bus;
    logic [1:0]  exp_aok, exp_dok;
    do_reset();
    for (int m = 0; m < 2; m++) begin
      rq[m] = 0; rwr[m] = 0; rsz[m] = 0; rsb[m] = 0; rad[m] = 0; rwd[m] = 0;
    end
    held = -1; rr_last = 0; perr = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!rq[m] && $urandom_range(0, 2) == 0) begin
          rq[m] = 1; rwr[m] = 1'($urandom_range(0, 1)); rsz[m] = 2'($urandom_range(0, 2));
          rsb[m] = 4'($urandom); rad[m] = $urandom; rwd[m] = $urandom;
        end
      end
      inst_req = rq[0]; inst_wr = rwr[0]; inst_size = rsz[0]; inst_wstrb = rsb[0]; inst_addr = rad[0]; inst_wdata = rwd[0];
      data_req = rq[1]; data_wr = rwr[1]; data_size = rsz[1]; data_wstrb = rsb[1]; data_addr = rad[1]; data_wdata = rwd[1];
      bus_addr_ok = ($urandom_range(0, 3) != 0);
      bus_data_ok = (q.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      bus_rdata = $urandom;
      #1;
      if (held >= 0) s = held;
`ifdef SRAM_ARB_RR_EN
      else if (rq[0] && rq[1]) s = 1 - rr_last;
`else
      else if (rq[0] && rq[1]) s = 1;
`endif
      else s = rq[1] ? 1 : 0;
      breq = (q.size() < 4) && rq[s];
      exp_bus = breq ? {rwr[s], rsz[s], rsb[s], rad[s], rwd[s]} : '0;
      exp_aok = '0; exp_dok = '0;
      if (breq && bus_addr_ok) exp_aok[s] = 1'b1;
      if (bus_data_ok && q.size() != 0) exp_dok[q[0]] = 1'b1;
      n_vec++; if (bus_req !== breq) begin n_err++; $display("FAIL rnd_bus_req c%0d: got %b want %b", c, bus_req, breq); end
      n_vec++; if ({bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !== exp_bus) begin n_err++; $display("FAIL rnd_bus_fields c%0d: got %h want %h", c, {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}, exp_bus); end
      n_vec++; if ({data_addr_ok, inst_addr_ok} !== exp_aok) begin n_err++; $display("FAIL rnd_addr_ok c%0d: got %b want %b", c, {data_addr_ok, inst_addr_ok}, exp_aok); end
      n_vec++; if ({data_data_ok, inst_data_ok} !== exp_dok) begin n_err++; $display("FAIL rnd_data_ok c%0d: got %b want %b", c, {data_data_ok, inst_data_ok}, exp_dok); end
      n_vec++; if (inst_rdata !== bus_rdata || data_rdata !== bus_rdata) begin n_err++; $display("FAIL rnd_rdata c%0d: got %h/%h want %h", c, inst_rdata, data_rdata, bus_rdata); end
      n_vec++; if (ost_cnt !== 3'(q.size())) begin n_err++; $display("FAIL rnd_ost_cnt c%0d: got %0d want %0d", c, ost_cnt, q.size()); end
      n_vec++; if (proto_err !== perr) begin n_err++; $display("FAIL rnd_proto_err c%0d: got %b want %b", c, proto_err, perr); end
      if (bus_data_ok) begin
        if (q.size() != 0) void'(q.pop_front());
        else perr = 1;
      end
      if (breq && bus_addr_ok) begin
        q.push_back(s); held = -1; rr_last = s; rq[s] = 0;
      end else if (breq) begin
        held = s;
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_single_read();
    test_both_req();
    test_full();
    test_lock();
    test_proto_err();
    test_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
